// File: rtl/cdb_arbiter_if.sv
// Functional-unit result ports and CDB broadcast bundle for cdb_arbiter.
// master: the arbiter side. slave: the FU / PRF / reservation-station side.
// XLEN is normally supplied by riscv_header.sv; it falls back to 32 here if undefined.
`ifndef XLEN
`define XLEN 32
`endif

interface cdb_arbiter_if #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned TAG_W  = 6
);
  logic [NUM_FU-1:0]         fu_valid;
  logic [NUM_FU*TAG_W-1:0]   fu_tag;
  logic [NUM_FU*`XLEN-1:0]   fu_data;
  logic [NUM_FU-1:0]         fu_ready;
  logic                      flush;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [`XLEN-1:0]          cdb_data;

  modport master (
    input  fu_valid, fu_tag, fu_data, flush,
    output fu_ready, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    output fu_valid, fu_tag, fu_data, flush,
    input  fu_ready, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin pick of one FU result per cycle, registered broadcast.
// Optional feature macro: CDB_PERF_CNT_EN adds a 32-bit saturating stall_count output.
// XLEN is normally supplied by riscv_header.sv; it falls back to 32 here if undefined.
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  cdb_arbiter_if.master     bus
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [PTR_W-1:0]  grant_idx;
  logic [NUM_FU-1:0] grant;
  logic              grant_vld;
  logic [TAG_W-1:0]  sel_tag;
  logic [`XLEN-1:0]  sel_data;
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [`XLEN-1:0]  cdb_data_q;

  // Round-robin search from rr_ptr; flush and reset suppress every grant.
  always_comb begin
    logic [PTR_W:0] pos;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = '0;
    if (rst_n && !bus.flush) begin
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        pos = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
        if (pos >= (PTR_W+1)'(NUM_FU)) begin
          pos = pos - (PTR_W+1)'(NUM_FU);
        end
        if (!grant_vld && bus.fu_valid[pos[PTR_W-1:0]]) begin
          grant_vld                 = 1'b1;
          grant_idx                 = pos[PTR_W-1:0];
          grant[pos[PTR_W-1:0]]     = 1'b1;
        end
      end
    end
  end

  // One-hot mux of the winning FU's tag and data.
  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        sel_tag  = bus.fu_tag[i*TAG_W +: TAG_W];
        sel_data = bus.fu_data[i*`XLEN +: `XLEN];
      end
    end
  end

  // Pointer moves just past the winner, wrapping at NUM_FU.
  always_comb begin
    if (grant_idx == PTR_W'(NUM_FU - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_idx + PTR_W'(1);
    end
  end

  // Pointer register; holds when nothing is granted (including during flush).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (grant_vld) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Broadcast register; tag/data hold when idle so the PRF ports see stable values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      cdb_valid_q <= grant_vld;
      if (grant_vld) begin
        cdb_tag_q  <= sel_tag;
        cdb_data_q <= sel_data;
      end
    end
  end

  assign bus.fu_ready  = grant;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] stall_q;

  // Count cycles where some valid FU lost arbitration; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!bus.flush && ($countones(bus.fu_valid) > 1) && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected broadcasts, a monitor pops them.
`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_arbiter;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
  } bcast_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcast_t     exp_q[$];
  logic [5:0]  t_arr[4];
  logic [31:0] d_arr[4];
  logic [31:0] phys_reg[64];
  logic [63:0] prf_vbits;

  cdb_arbiter_if #(.NUM_FU(4), .TAG_W(6)) bus ();

`ifdef CDB_PERF_CNT_EN
  logic [31:0] stall_count;
`endif

  cdb_arbiter #(
    .NUM_FU (4),
    .TAG_W  (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CDB_PERF_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_fu(input int i, input logic [5:0] tag, input logic [31:0] data);
    t_arr[i] = tag;
    d_arr[i] = data;
    bus.fu_tag[i*6 +: 6]           = tag;
    bus.fu_data[i*`XLEN +: `XLEN]  = data;
  endtask

  // Drive one cycle, check the grant mid-cycle and queue the broadcast it implies.
  task automatic cycle(input logic [3:0] v, input logic fl, input logic [3:0] exp_rdy);
    bcast_t e;
    bus.fu_valid = v;
    bus.flush    = fl;
    @(negedge clk);
    chk("fu_ready", 64'(bus.fu_ready), 64'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        e.tag  = t_arr[i];
        e.data = d_arr[i];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every broadcast must match the oldest expected entry.
  always @(negedge clk) begin
    bcast_t e;
    if (rst_n === 1'b1 && bus.cdb_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_broadcast: got valid=%b tag %0d data %0h expected no broadcast",
                 bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      end else begin
        e = exp_q.pop_front();
        chk("cdb_tag", 64'(bus.cdb_tag), 64'(e.tag));
        chk("cdb_data", 64'(bus.cdb_data), 64'(e.data));
      end
    end
  end

  // PRF model written straight from the CDB.
  always @(posedge clk) begin
    if (!rst_n) begin
      prf_vbits <= '0;
    end else if (bus.cdb_valid) begin
      phys_reg[bus.cdb_tag]  <= bus.cdb_data;
      prf_vbits[bus.cdb_tag] <= 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.flush    = 1'b0;
    bus.fu_valid = 4'b1111;
    bus.fu_tag   = '0;
    bus.fu_data  = '0;
    for (int i = 0; i < 4; i++) set_fu(i, 6'(10 + i), 32'hA000_0000 + 32'(i));

    // Reset with all FUs valid: outputs idle.
    #3;
    chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_cdb_tag", 64'(bus.cdb_tag), 64'd0);
    chk("rst_cdb_data", 64'(bus.cdb_data), 64'd0);
    chk("rst_fu_ready", 64'(bus.fu_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin with all four valid: 0,1,2,3,0,1.
    cycle(4'b1111, 1'b0, 4'b0001);
    cycle(4'b1111, 1'b0, 4'b0010);
    cycle(4'b1111, 1'b0, 4'b0100);
    cycle(4'b1111, 1'b0, 4'b1000);
    cycle(4'b1111, 1'b0, 4'b0001);
    cycle(4'b1111, 1'b0, 4'b0010);
`ifdef CDB_PERF_CNT_EN
    chk("stall_count_rr", 64'(stall_count), 64'd6);
`endif

    // Mid-stream asynchronous reset.
    rst_n = 1'b0;
    #1;
    chk("arst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("arst_cdb_tag", 64'(bus.cdb_tag), 64'd0);
    chk("arst_cdb_data", 64'(bus.cdb_data), 64'd0);
    chk("arst_fu_ready", 64'(bus.fu_ready), 64'd0);
`ifdef CDB_PERF_CNT_EN
    chk("arst_stall_count", 64'(stall_count), 64'd0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(4'b1111, 1'b0, 4'b0001);  // first grant from pointer 0
`ifdef CDB_PERF_CNT_EN
    chk("stall_count_post_rst", 64'(stall_count), 64'd1);
`endif

    // Single FU2, tag 17: same-cycle grant, broadcast next cycle, PRF updated.
    set_fu(2, 6'd17, 32'hDEAD_BEEF);
    cycle(4'b0100, 1'b0, 4'b0100);
    chk("single_cdb_valid", 64'(bus.cdb_valid), 64'd1);
    cycle(4'b0000, 1'b0, 4'b0000);
    chk("prf_reg17", 64'(phys_reg[17]), 64'hDEAD_BEEF);
    chk("prf_vbit17", 64'(prf_vbits[17]), 64'd1);

    // Pointer skip: ptr=1 with FU0 and FU3 valid -> FU3 then FU0.
    cycle(4'b0001, 1'b0, 4'b0001);  // ptr 3 -> 1
    cycle(4'b1001, 1'b0, 4'b1000);
    cycle(4'b0001, 1'b0, 4'b0001);

    // Flush with a broadcast registered and FU1 valid; pointer stays at 1.
    cycle(4'b0001, 1'b0, 4'b0001);
    cycle(4'b0011, 1'b1, 4'b0000);
    chk("flush_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    cycle(4'b0011, 1'b0, 4'b0010);
    cycle(4'b0001, 1'b0, 4'b0001);  // ptr 2 -> FU0, ptr becomes 1

    // Duplicate tags: FU0 and FU1 both target tag 5.
    cycle(4'b1000, 1'b0, 4'b1000);  // ptr 1 -> FU3, ptr becomes 0
    set_fu(0, 6'd5, 32'h1);
    set_fu(1, 6'd5, 32'h2);
    cycle(4'b0011, 1'b0, 4'b0001);
    cycle(4'b0010, 1'b0, 4'b0010);
    cycle(4'b0000, 1'b0, 4'b0000);
    cycle(4'b0000, 1'b0, 4'b0000);
    chk("prf_reg5", 64'(phys_reg[5]), 64'd2);

    cycle(4'b0000, 1'b0, 4'b0000);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
